ks_add_rr_scheduler: RTL and testbench

//  Round-robin scheduler sharing one registered Kogge-Stone adder (kogge_stone_Nbit, LAT cycles)

---
 rtl/ks_add_rr_scheduler.sv | 189 ++++++++++++++++++
 tb/tb_ks_add_rr_scheduler.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ks_add_rr_scheduler.sv
// Round-robin scheduler sharing one registered adder between NREQ requesters, with tagged
// in-order responses through a credit-protected FIFO. Optional carry chaining: KS_SCHED_CHAIN_EN.
module ks_add_rr_scheduler #(
  parameter int BW     = 16,
  parameter int NREQ   = 4,
  parameter int LAT    = 1,
  parameter int FDEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*BW-1:0]       req_a,
  input  logic [NREQ*BW-1:0]       req_b,
  input  logic [NREQ-1:0]          req_cin,
`ifdef KS_SCHED_CHAIN_EN
  input  logic [NREQ-1:0]          req_chain,
`endif
  output logic [BW-1:0]            add_a,
  output logic [BW-1:0]            add_b,
  output logic                     add_cin,
  input  logic [BW-1:0]            add_sum,
  input  logic                     add_cout,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [BW-1:0]            rsp_sum,
  output logic                     rsp_cout
);
  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(FDEPTH + 1);
  localparam int PW  = (FDEPTH > 1) ? $clog2(FDEPTH) : 1;
  localparam int EW  = IDW + BW + 1;

  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [CW-1:0]   credits_q, credits_d, count_q, count_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic            sr_valid_q [LAT];
  logic            sr_valid_d [LAT];
  logic [IDW-1:0]  sr_id_q [LAT];
  logic [IDW-1:0]  sr_id_d [LAT];
  logic [EW-1:0]   fifo_mem [FDEPTH];
  logic [EW-1:0]   head;
  logic [NREQ-1:0] eligible;
  logic [IDW-1:0]  grant_id;
  logic            grant_any, push, pop;
  int              idx;

`ifdef KS_SCHED_CHAIN_EN
  logic            lock_q, lock_d, pend_q, pend_d, carry_q, carry_d;
  logic [IDW-1:0]  lock_id_q, lock_id_d;
  logic            sr_chain_q [LAT];
  logic            sr_chain_d [LAT];
  logic            chain_ret, chain_ok;

  // The chained beat's result is the newest in flight, so its tag marks when the carry is back.
  assign chain_ret = sr_valid_q[LAT-1] & sr_chain_q[LAT-1];
  assign chain_ok  = !pend_q || chain_ret;
  always_comb begin
    eligible = req_valid;
    if (lock_q) eligible = req_valid & (NREQ'(1) << lock_id_q) & {NREQ{chain_ok}};
  end
`else
  assign eligible = req_valid;
`endif

  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    idx       = 0;
    if (!RESET && credits_q != '0) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (int'(ptr_q) + k) % NREQ;
        if (!grant_any && eligible[idx]) begin
          grant_any = 1'b1;
          grant_id  = IDW'(idx);
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    add_a     = '0;
    add_b     = '0;
    add_cin   = 1'b0;
    if (grant_any) begin
      req_ready[grant_id] = 1'b1;
      add_a   = req_a[grant_id*BW +: BW];
      add_b   = req_b[grant_id*BW +: BW];
      add_cin = req_cin[grant_id];
`ifdef KS_SCHED_CHAIN_EN
      if (lock_q) add_cin = pend_q ? add_cout : carry_q;
`endif
    end
  end

  assign push = sr_valid_q[LAT-1];
  assign pop  = rsp_ready && (count_q != '0);

  always_comb begin
    sr_valid_d[0] = grant_any;
    sr_id_d[0]    = grant_id;
    for (int i = 1; i < LAT; i++) begin
      sr_valid_d[i] = sr_valid_q[i-1];
      sr_id_d[i]    = sr_id_q[i-1];
    end
    ptr_d = ptr_q;
    if (grant_any) ptr_d = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
    // A grant and a pop in the same cycle cancel out.
    credits_d = credits_q - CW'(grant_any) + CW'(pop);
    count_d   = count_q + CW'(push) - CW'(pop);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (push) wr_ptr_d = (wr_ptr_q == PW'(FDEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = (rd_ptr_q == PW'(FDEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
  end

`ifdef KS_SCHED_CHAIN_EN
  always_comb begin
    lock_d        = lock_q;
    lock_id_d     = lock_id_q;
    pend_d        = pend_q;
    carry_d       = carry_q;
    sr_chain_d[0] = grant_any & req_chain[grant_id];
    for (int i = 1; i < LAT; i++) sr_chain_d[i] = sr_chain_q[i-1];
    if (chain_ret) begin
      carry_d = add_cout;
      pend_d  = 1'b0;
    end
    if (grant_any) begin
      lock_d    = req_chain[grant_id];
      lock_id_d = grant_id;
      if (req_chain[grant_id]) pend_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      lock_q    <= 1'b0;
      lock_id_q <= '0;
      pend_q    <= 1'b0;
      carry_q   <= 1'b0;
      for (int i = 0; i < LAT; i++) sr_chain_q[i] <= 1'b0;
    end else begin
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      pend_q    <= pend_d;
      carry_q   <= carry_d;
      for (int i = 0; i < LAT; i++) sr_chain_q[i] <= sr_chain_d[i];
    end
  end
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ptr_q     <= '0;
      credits_q <= CW'(FDEPTH);
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      for (int i = 0; i < LAT; i++) begin
        sr_valid_q[i] <= 1'b0;
        sr_id_q[i]    <= '0;
      end
    end else begin
      ptr_q     <= ptr_d;
      credits_q <= credits_d;
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      for (int i = 0; i < LAT; i++) begin
        sr_valid_q[i] <= sr_valid_d[i];
        sr_id_q[i]    <= sr_id_d[i];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET && push) fifo_mem[wr_ptr_q] <= {sr_id_q[LAT-1], add_cout, add_sum};
  end

  // Head fields are masked so an empty FIFO presents zeros rather than stale data.
  assign head      = fifo_mem[rd_ptr_q];
  assign rsp_valid = !RESET && (count_q != '0);
  assign rsp_id    = rsp_valid ? head[EW-1 -: IDW] : '0;
  assign rsp_cout  = rsp_valid ? head[BW] : 1'b0;
  assign rsp_sum   = rsp_valid ? head[BW-1:0] : '0;
endmodule

// File: tb/tb_ks_add_rr_scheduler.sv
// Bench for ks_add_rr_scheduler: queue-based reference model checked every cycle plus
// directed scenarios with literal expectations; includes the chain scenario when enabled.
module tb_ks_add_rr_scheduler;
  localparam int BW = 16, NREQ = 4, LAT = 1, FDEPTH = 4;
  localparam int IDW = $clog2(NREQ);
`ifdef KS_SCHED_CHAIN_EN
  localparam bit CHAIN_EN = 1'b1;
`else
  localparam bit CHAIN_EN = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RESET;
  logic [NREQ-1:0] req_valid, req_ready, req_cin, req_chain;
  logic [NREQ*BW-1:0] req_a, req_b;
  logic [BW-1:0] add_a, add_b, add_sum, rsp_sum;
  logic add_cin, add_cout, rsp_valid, rsp_ready, rsp_cout;
  logic [IDW-1:0] rsp_id;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  ks_add_rr_scheduler #(.BW(BW), .NREQ(NREQ), .LAT(LAT), .FDEPTH(FDEPTH)) dut (
    .CLK(CLK), .RESET(RESET), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
`ifdef KS_SCHED_CHAIN_EN
    .req_chain(req_chain),
`endif
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
    .rsp_cout(rsp_cout));

  // Registered adder standing in for the shared Kogge-Stone instance (LAT = 1).
  always_ff @(posedge CLK) {add_cout, add_sum} <= {1'b0, add_a} + {1'b0, add_b} + {{BW{1'b0}}, add_cin};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: arbitration from the pointer rule, responses as a timed queue of sums.
  typedef struct { int issue; logic [IDW+BW:0] e; } pe_t;
  pe_t m_pipe[$];
  logic [IDW+BW:0] m_fifo[$];
  int  m_ptr = 0, cyc = 0, m_lock_id = 0, m_chain_issue = 0;
  bit  m_lock = 0;
  logic m_carry = 1'b0;

  always @(negedge CLK) begin
    int credits, g;
    logic [NREQ-1:0] exp_rdy;
    logic [BW-1:0] ea, eb;
    logic ecin;
    logic [BW:0] s;
    logic [IDW+BW:0] h;
    if (RESET) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_add_a", add_a, 0);
      m_pipe.delete(); m_fifo.delete();
      m_ptr = 0; m_lock = 0; m_carry = 1'b0;
    end else begin
      credits = FDEPTH - m_fifo.size() - m_pipe.size();
      g = -1;
      if (credits > 0)
        for (int k = 0; k < NREQ; k++) begin
          int i;
          i = (m_ptr + k) % NREQ;
          if (g < 0 && req_valid[i] && (!m_lock || (i == m_lock_id && cyc >= m_chain_issue + LAT)))
            g = i;
        end
      exp_rdy = '0; ea = '0; eb = '0; ecin = 1'b0;
      if (g >= 0) begin
        exp_rdy[g] = 1'b1;
        ea = req_a[g*BW +: BW];
        eb = req_b[g*BW +: BW];
        ecin = m_lock ? m_carry : req_cin[g];
      end
      chk("req_ready", req_ready, exp_rdy);
      chk("add_a", add_a, ea);
      chk("add_b", add_b, eb);
      chk("add_cin", add_cin, ecin);
      chk("rsp_valid", rsp_valid, m_fifo.size() > 0);
      if (m_fifo.size() > 0) begin
        h = m_fifo[0];
        chk("rsp_id", rsp_id, h[IDW+BW:BW+1]);
        chk("rsp_sum", rsp_sum, h[BW-1:0]);
        chk("rsp_cout", rsp_cout, h[BW]);
        if (rsp_ready) void'(m_fifo.pop_front());
      end
      while (m_pipe.size() > 0 && m_pipe[0].issue + LAT == cyc) begin
        m_fifo.push_back(m_pipe[0].e);
        void'(m_pipe.pop_front());
      end
      if (g >= 0) begin
        s = {1'b0, ea} + {1'b0, eb} + {{BW{1'b0}}, ecin};
        m_pipe.push_back('{issue: cyc, e: {IDW'(g), s}});
        m_ptr = (g + 1) % NREQ;
        if (CHAIN_EN) begin
          m_lock = req_chain[g];
          m_lock_id = g;
          if (req_chain[g]) begin
            m_chain_issue = cyc;
            m_carry = s[BW];
          end
        end
      end
    end
    cyc++;
  end

  task automatic tick(); @(posedge CLK); #1; endtask

  task automatic set_req(input int i, input logic [BW-1:0] a, input logic [BW-1:0] b,
                         input logic cin, input logic ch);
    req_a[i*BW +: BW] = a;
    req_b[i*BW +: BW] = b;
    req_cin[i] = cin;
    req_chain[i] = ch;
  endtask

  task automatic do_reset(input int n);
    RESET = 1'b1;
    repeat (n) tick();
    RESET = 1'b0;
  endtask

  initial begin
    int grants;
    RESET = 1'b1; req_valid = '1; rsp_ready = 1'b1;
    req_a = '0; req_b = '0; req_cin = '0; req_chain = '0;
    for (int i = 0; i < NREQ; i++) set_req(i, BW'(16'h1111 * (i + 1)), BW'(16'h0101 * (i + 3)), i[0], 1'b0);
    #1;
    // 1: reset held two cycles with every requester pending
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      chk("t1_req_ready", req_ready, 0);
      chk("t1_rsp_valid", rsp_valid, 0);
      tick();
    end
    RESET = 1'b0;
    $display("t1 reset done");

    // 2: single add 0xFFFF + 1
    req_valid = 4'b0001; set_req(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    @(negedge CLK); chk("t2_grant", req_ready, 4'b0001);
    tick(); req_valid = '0;
    @(negedge CLK); chk("t2_early", rsp_valid, 0);
    tick();
    @(negedge CLK);
    chk("t2_valid", rsp_valid, 1); chk("t2_id", rsp_id, 0);
    chk("t2_sum", rsp_sum, 16'h0000); chk("t2_cout", rsp_cout, 1);
    $display("t2 single: id=%0d sum=%h cout=%b", rsp_id, rsp_sum, rsp_cout);
    tick();

    // 3: round-robin fairness from a reset pointer
    do_reset(1);
    for (int i = 0; i < NREQ; i++) set_req(i, BW'(16'h2000 * i + 7), BW'(16'h0F00 + i), i[1], 1'b0);
    req_valid = '1;
    for (int c = 0; c < 8; c++) begin
      @(negedge CLK);
      chk("t3_grant", req_ready, 4'b0001 << (c % 4));
      if (c >= 2) chk("t3_rsp_id", rsp_id, (c - 2) % 4);
      $display("t3 cycle %0d: grant=%b rsp_id=%0d", c, req_ready, rsp_id);
      tick();
    end
    req_valid = '0;
    repeat (3) tick();

    // 4: backpressure bounds grants to the FIFO depth
    rsp_ready = 1'b0; req_valid = '1; grants = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge CLK); if (req_ready != 0) grants++;
      tick();
    end
    chk("t4_grants", grants, FDEPTH);
    @(negedge CLK); chk("t4_stalled", req_ready, 0);
    tick(); rsp_ready = 1'b1;
    tick(); rsp_ready = 1'b0; grants = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK); if (req_ready != 0) grants++;
      tick();
    end
    chk("t4_one_more", grants, 1);
    $display("t4 backpressure: extra grants after one pop=%0d", grants);
    req_valid = '0; rsp_ready = 1'b1;
    repeat (6) tick();

    // 5: reset while two adds are in flight
    req_valid = 4'b0001;
    repeat (2) tick();
    req_valid = '0;
    do_reset(1);
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK); chk("t5_no_rsp", rsp_valid, 0);
      tick();
    end
    rsp_ready = 1'b0; req_valid = '1; grants = 0;
    for (int c = 0; c < 7; c++) begin
      @(negedge CLK); if (req_ready != 0) grants++;
      tick();
    end
    chk("t5_credits", grants, FDEPTH);
    $display("t5 reset mid-flight: grants after reset=%0d", grants);
    req_valid = '0; rsp_ready = 1'b1;
    repeat (6) tick();

`ifdef KS_SCHED_CHAIN_EN
    // 6: two-beat carry chain on requester 1 while requester 2 waits
    do_reset(1);
    set_req(1, 16'hFFFF, 16'h0001, 1'b0, 1'b1);
    set_req(2, 16'h0005, 16'h0006, 1'b0, 1'b0);
    req_valid = 4'b0110;
    @(negedge CLK); chk("t6_beat1", req_ready, 4'b0010);
    tick(); set_req(1, 16'h0000, 16'h0000, 1'b0, 1'b0);
    @(negedge CLK); chk("t6_beat2", req_ready, 4'b0010); chk("t6_cin", add_cin, 1);
    tick(); req_valid = 4'b0100;
    @(negedge CLK); chk("t6_req2", req_ready, 4'b0100);
    tick(); req_valid = '0;
    @(negedge CLK); chk("t6_id", rsp_id, 1); chk("t6_sum", rsp_sum, 16'h0001);
    $display("t6 chain: second beat sum=%h", rsp_sum);
    repeat (3) tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
